mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Owns data port B of Memory and sequences boot: after reset the UART loader writes the program
//  while the core is held in reset; then the port is handed to the MEM stage and the core is
//  released. A reload pulse takes the port back and re-enters load. Replaces the ad-hoc
//  uart_done muxing at CPU top; sits between UART/Stage_MEM and Memory port B.
// PARAMETERS
//  ADDR_W         32  address width, byte address
//  DATA_W         32  word width
//  SETTLE_CYCLES  4   idle cycles between last UART write and core release (>=1)
//  CNT_W          16  width of loaded-word counter
// PORTS
//  clk         in   1       core clock (cpuclk domain)
//  rst_n       in   1       asynchronous, active-low reset
//  uart_valid  in   1       UART word available
//  uart_ready  out  1       arbiter accepts word (valid&ready = transfer)
//  uart_addr   in   ADDR_W  byte address of UART word
//  uart_data   in   DATA_W  UART word
//  uart_done   in   1       level; rising edge = program load finished
//  reload      in   1       1-cycle pulse: restart load, hold core in reset
//  cpu_addr    in   ADDR_W  MEM-stage address (mem_addr)
//  cpu_wdata   in   DATA_W  MEM-stage write data
//  cpu_we      in   1       MEM-stage write enable, active high
//  mem_addr    out  ADDR_W  to Memory addrb
//  mem_wdata   out  DATA_W  to Memory write_datab
//  mem_we      out  1       to Memory web, active high
//  cpu_rst_n   out  1       core reset, active low, registered
//  loading     out  1       1 in LOAD/SETTLE (LED)
//  load_err    out  1       sticky: unaligned UART address seen this load
//  word_cnt    out  CNT_W   words written this load, saturating
// BEHAVIOUR
//  States: LOAD, SETTLE, RUN. Reset -> LOAD, cpu_rst_n=0, uart_ready=0 (first cycle), pend=0,
//   word_cnt=0, load_err=0, done_q=0, mem_* = 0.
//  uart_ready = (state==LOAD) registered-combinational: 1 every LOAD cycle after reset edge.
//  LOAD: transfer at edge N loads pend register {addr,data}; cycle N+1 drives mem_addr/mem_wdata
//   from pend, mem_we=1. Throughput 1 word/cycle. Idle cycles: mem_we=0, addr/wdata=0.
//  Unaligned (uart_addr[1:0]!=0): word accepted, NOT written (pend not set), load_err<=1.
//  Aligned write increments word_cnt; saturates at 2^CNT_W-1.
//  done_rise = uart_done & ~done_q (done_q registered). In LOAD, done_rise -> SETTLE next edge;
//   a word transferred the same cycle is accepted and its write issues in first SETTLE cycle.
//   uart_done already high out of reset/reload does not trigger; needs a fresh 0->1.
//  SETTLE: uart_ready=0; pending write drains; counter runs SETTLE_CYCLES cycles, then RUN.
//  RUN: mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=cpu_we combinationally (no added latency);
//   cpu_rst_n=1 from first RUN cycle (registered on SETTLE->RUN edge). UART inputs ignored.
//  reload (any state, highest priority): next state LOAD, cpu_rst_n<=0 same edge, pend dropped,
//   word_cnt<=0, load_err<=0, settle counter cleared. reload with done_rise: reload wins.
//  cpu_we outside RUN never reaches mem_we. Async reset mid-load: all state to reset values.
// TESTING
//  1 reset, 3 aligned words 0x0/0x4/0x8 back-to-back -> mem_we high 3 cycles, 1 cycle after each
//    transfer, word_cnt=3, cpu_rst_n=0.
//  2 uart_done 0->1 with last word same cycle -> last write in SETTLE cycle 1; cpu_rst_n=1 exactly
//    SETTLE_CYCLES+1 edges after done edge; then cpu_addr=0x1000,cpu_we=1 -> mem_we=1 same cycle.
//  3 uart_addr=0x6 -> no mem_we, load_err=1, word_cnt unchanged; reload -> load_err=0, word_cnt=0.
//  4 reload in RUN while cpu_we=1 -> next cycle cpu_rst_n=0, mem_we=0, uart_ready=1.
//  5 uart_done held high across reload -> stays in LOAD until uart_done drops and rises again.
//  6 CNT_W=2, write 5 words -> word_cnt=3; rst_n pulsed mid-load -> all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Memory port B owner and boot sequencer.
// Holds the core in reset while the UART loader writes the program, waits a
// short settle window, then hands port B to the MEM stage and releases the
// core. A reload pulse takes the port back and restarts the load.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_LOAD   | UART owns port B, core in reset, words accepted 1 per cycle
// ST_SETTLE | UART blocked, last pending write drains, settle timer counts
// ST_RUN    | MEM stage owns port B combinationally, core out of reset
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_valid,
  output logic              uart_ready,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_data,
  input  logic              uart_done,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic              load_err,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // Settle timer is a down-counter loaded with SETTLE_CYCLES-1; terminal count 0.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t              state;
  state_t              state_nxt;
  logic                done_q;
  logic                done_armed;
  logic                done_rise;
  logic                xfer;
  logic                aligned;
  logic                ready_q;
  logic                cpu_rst_q;
  logic                pend_v;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_data;
  logic [SET_W-1:0]    settle_cnt;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;

  // done_armed requires uart_done to have been seen low since reset/reload,
  // so a level already high out of reset or across a reload never counts.
  assign done_rise = uart_done & ~done_q & done_armed;
  // ready_q is only ever high while in ST_LOAD, so it alone qualifies a transfer.
  assign xfer      = uart_valid & ready_q;
  assign aligned   = (uart_addr[1:0] == 2'b00);

  assign uart_ready = ready_q;
  assign cpu_rst_n  = cpu_rst_q;
  assign load_err   = err_q;
  assign word_cnt   = cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; reload overrides everything including a done edge.
  always_comb begin
    state_nxt = state;
    if (reload) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD:   if (done_rise) state_nxt = ST_SETTLE;
        ST_SETTLE: if (settle_cnt == '0) state_nxt = ST_RUN;
        ST_RUN:    state_nxt = ST_RUN;
        default:   state_nxt = ST_LOAD;
      endcase
    end
  end

  // Port B mux: MEM stage passes straight through in RUN, otherwise the pending UART write.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    loading   = 1'b1;
    if (state == ST_RUN) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we;
      loading   = 1'b0;
    end else if (pend_v) begin
      mem_addr  = pend_addr;
      mem_wdata = pend_data;
      mem_we    = 1'b1;
    end
  end

  // Registered handshake and core reset, both derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b0;
    end else begin
      ready_q   <= (state_nxt == ST_LOAD);
      cpu_rst_q <= (state_nxt == ST_RUN);
    end
  end

  // Pending write register: one-cycle pipeline from UART transfer to port B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v    <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (reload) begin
      pend_v    <= 1'b0;
    end else if (xfer && aligned) begin
      pend_v    <= 1'b1;
      pend_addr <= uart_addr;
      pend_data <= uart_data;
    end else begin
      pend_v    <= 1'b0;
    end
  end

  // Settle down-counter, loaded on the LOAD->SETTLE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
    end else if (reload) begin
      settle_cnt <= '0;
    end else if (state == ST_LOAD && state_nxt == ST_SETTLE) begin
      settle_cnt <= SETTLE_LAST;
    end else if (state == ST_SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Load statistics: saturating word count and sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (reload) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (xfer) begin
      if (aligned) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  // uart_done edge detection with re-arm on reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      done_armed <= 1'b0;
    end else begin
      done_q <= uart_done;
      if (reload) begin
        done_armed <= 1'b0;
      end else if (!uart_done) begin
        done_armed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed boot/reload scenarios plus randomized
// traffic against a phase-level reference model.
module tb_mem_port_arbiter;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        uart_valid, uart_done, reload, cpu_we;
  logic [31:0] uart_addr, uart_data, cpu_addr, cpu_wdata;

  logic        uart_ready, mem_we, cpu_rst_n, loading, load_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] word_cnt;

  logic        uart_ready2, mem_we2, cpu_rst_n2, loading2, load_err2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [1:0]  word_cnt2;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_valid(uart_valid), .uart_ready(uart_ready), .uart_addr(uart_addr),
    .uart_data(uart_data), .uart_done(uart_done), .reload(reload),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_rst_n(cpu_rst_n), .loading(loading), .load_err(load_err), .word_cnt(word_cnt)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .SETTLE_CYCLES(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .uart_valid(uart_valid), .uart_ready(uart_ready2), .uart_addr(uart_addr),
    .uart_data(uart_data), .uart_done(uart_done), .reload(reload),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2),
    .cpu_rst_n(cpu_rst_n2), .loading(loading2), .load_err(load_err2), .word_cnt(word_cnt2)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: boot phase (0 load, 1 settle, 2 run), settle cycles left,
  // write expected on port B this cycle, words loaded as a plain integer.
  int          m_phase, m_left, m_cnt;
  bit          m_ready, m_pv, m_err, m_crst, m_prev_low;
  logic [31:0] m_pa, m_pd;

  // Expected outputs for the current cycle.
  logic        e_ready, e_we, e_crst, e_loading, e_err;
  logic [31:0] e_addr, e_wdata;
  logic [15:0] e_cnt16;
  logic [1:0]  e_cnt2;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_cnt = 0;
    m_ready = 0; m_pv = 0; m_err = 0; m_crst = 0; m_prev_low = 0;
    m_pa = '0; m_pd = '0;
  endtask

  // Apply inputs just after a rising edge, then stop at the falling edge with expectations ready.
  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] d,
                       input bit dn, input bit rl,
                       input logic [31:0] ca, input logic [31:0] cd, input bit cw);
    uart_valid = v; uart_addr = a; uart_data = d; uart_done = dn; reload = rl;
    cpu_addr = ca; cpu_wdata = cd; cpu_we = cw;
    @(negedge clk);
    e_ready   = m_ready;
    e_crst    = m_crst;
    e_loading = (m_phase != 2);
    e_err     = m_err;
    e_cnt16   = 16'((m_cnt > 65535) ? 65535 : m_cnt);
    e_cnt2    = 2'((m_cnt > 3) ? 3 : m_cnt);
    if (m_phase == 2) begin
      e_we = cw; e_addr = ca; e_wdata = cd;
    end else begin
      e_we = m_pv; e_addr = m_pv ? m_pa : 32'h0; e_wdata = m_pv ? m_pd : 32'h0;
    end
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic advance();
    bit xfer, rise;
    if (!rst_n) begin
      model_reset();
    end else begin
      xfer = uart_valid && m_ready;
      rise = uart_done && m_prev_low;
      m_prev_low = !uart_done && !reload;
      if (reload) begin
        m_phase = 0; m_ready = 1; m_pv = 0; m_cnt = 0; m_err = 0; m_crst = 0; m_left = 0;
      end else if (m_phase == 0) begin
        m_pv = 0;
        if (xfer) begin
          if (uart_addr[1:0] == 2'b00) begin
            m_pv = 1; m_pa = uart_addr; m_pd = uart_data; m_cnt++;
          end else begin
            m_err = 1;
          end
        end
        if (rise) begin
          m_phase = 1; m_left = S; m_ready = 0;
        end else begin
          m_ready = 1;
        end
      end else if (m_phase == 1) begin
        m_pv = 0;
        m_left--;
        if (m_left == 0) begin
          m_phase = 2; m_crst = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit dn);
    drive(0, 32'h0, 32'h0, dn, 0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    idle(1);
    n_total++; if (uart_ready !== 1'b0) $display("FAIL rst_ready: got %0b exp 0", uart_ready); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %0b exp 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (cpu_rst_n !== 1'b0) $display("FAIL rst_cpu_rst_n: got %0b exp 0", cpu_rst_n); else n_pass++;
    n_total++; if (word_cnt !== 16'h0) $display("FAIL rst_word_cnt: got %0d exp 0", word_cnt); else n_pass++;
    n_total++; if (load_err !== 1'b0) $display("FAIL rst_load_err: got %0b exp 0", load_err); else n_pass++;
    n_total++; if (loading !== 1'b1) $display("FAIL rst_loading: got %0b exp 1", loading); else n_pass++;
    advance();
    idle(1);
    advance();
    rst_n = 1'b1;
    idle(1);
    n_total++; if (uart_ready !== 1'b0) $display("FAIL rst_first_ready: got %0b exp 0", uart_ready); else n_pass++;
    advance();
    // uart_done already high out of reset must not start the settle phase
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_total++; if (uart_ready !== 1'b1) $display("FAIL rst_done_high_ready: got %0b exp 1", uart_ready); else n_pass++;
      n_total++; if (loading !== 1'b1) $display("FAIL rst_done_high_loading: got %0b exp 1", loading); else n_pass++;
      advance();
    end
    idle(0);
    advance();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    for (int i = 0; i < 3; i++) d[i] = $urandom;
    drive(1, 32'h0, d[0], 0, 0, 32'h0, 32'h0, 1);
    n_total++; if (mem_we !== 1'b0) $display("FAIL b2b_we_pre: got %0b exp 0", mem_we); else n_pass++;
    advance();
    for (int i = 1; i <= 3; i++) begin
      if (i < 3) drive(1, 32'(4 * i), d[i], 0, 0, 32'h0, 32'h0, 1);
      else       drive(0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
      n_total++; if (mem_we !== 1'b1) $display("FAIL b2b_we%0d: got %0b exp 1", i, mem_we); else n_pass++;
      n_total++; if (mem_addr !== 32'(4 * (i - 1))) $display("FAIL b2b_addr%0d: got %h exp %h", i, mem_addr, 32'(4 * (i - 1))); else n_pass++;
      n_total++; if (mem_wdata !== d[i-1]) $display("FAIL b2b_data%0d: got %h exp %h", i, mem_wdata, d[i-1]); else n_pass++;
      advance();
    end
    idle(0);
    n_total++; if (mem_we !== 1'b0) $display("FAIL b2b_we_post: got %0b exp 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 32'h0) $display("FAIL b2b_addr_post: got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (word_cnt !== 16'd3) $display("FAIL b2b_word_cnt: got %0d exp 3", word_cnt); else n_pass++;
    n_total++; if (cpu_rst_n !== 1'b0) $display("FAIL b2b_cpu_rst_n: got %0b exp 0", cpu_rst_n); else n_pass++;
    advance();
  endtask

  task automatic test_done_settle();
    logic [31:0] d, cd;
    d  = $urandom;
    cd = $urandom;
    drive(1, 32'hC, d, 1, 0, 32'h0, 32'h0, 0);
    n_total++; if (uart_ready !== 1'b1) $display("FAIL done_ready_at_edge: got %0b exp 1", uart_ready); else n_pass++;
    advance();
    idle(1);
    n_total++; if (mem_we !== 1'b1) $display("FAIL settle1_we: got %0b exp 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 32'hC) $display("FAIL settle1_addr: got %h exp c", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== d) $display("FAIL settle1_data: got %h exp %h", mem_wdata, d); else n_pass++;
    n_total++; if (uart_ready !== 1'b0) $display("FAIL settle1_ready: got %0b exp 0", uart_ready); else n_pass++;
    n_total++; if (cpu_rst_n !== 1'b0) $display("FAIL settle1_cpu_rst_n: got %0b exp 0", cpu_rst_n); else n_pass++;
    advance();
    for (int i = 2; i <= S; i++) begin
      drive(0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 1);
      n_total++; if (cpu_rst_n !== 1'b0) $display("FAIL settle%0d_cpu_rst_n: got %0b exp 0", i, cpu_rst_n); else n_pass++;
      n_total++; if (mem_we !== 1'b0) $display("FAIL settle%0d_we: got %0b exp 0", i, mem_we); else n_pass++;
      n_total++; if (loading !== 1'b1) $display("FAIL settle%0d_loading: got %0b exp 1", i, loading); else n_pass++;
      advance();
    end
    drive(1, 32'h40, 32'h1234, 1, 0, 32'h1000, cd, 1);
    n_total++; if (cpu_rst_n !== 1'b1) $display("FAIL run_cpu_rst_n: got %0b exp 1", cpu_rst_n); else n_pass++;
    n_total++; if (loading !== 1'b0) $display("FAIL run_loading: got %0b exp 0", loading); else n_pass++;
    n_total++; if (mem_we !== 1'b1) $display("FAIL run_we: got %0b exp 1", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 32'h1000) $display("FAIL run_addr: got %h exp 1000", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== cd) $display("FAIL run_wdata: got %h exp %h", mem_wdata, cd); else n_pass++;
    cpu_we = 1'b0;
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL run_we_comb: got %0b exp 0", mem_we); else n_pass++;
    advance();
  endtask

  task automatic test_reload_run();
    drive(0, 32'h0, 32'h0, 1, 1, 32'h2000, 32'hAA, 1);
    n_total++; if (mem_we !== 1'b1) $display("FAIL reload_run_we_before: got %0b exp 1", mem_we); else n_pass++;
    advance();
    drive(0, 32'h0, 32'h0, 1, 0, 32'h2004, 32'hBB, 1);
    n_total++; if (cpu_rst_n !== 1'b0) $display("FAIL reload_run_cpu_rst_n: got %0b exp 0", cpu_rst_n); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL reload_run_we: got %0b exp 0", mem_we); else n_pass++;
    n_total++; if (uart_ready !== 1'b1) $display("FAIL reload_run_ready: got %0b exp 1", uart_ready); else n_pass++;
    n_total++; if (word_cnt !== 16'h0) $display("FAIL reload_run_word_cnt: got %0d exp 0", word_cnt); else n_pass++;
    advance();
  endtask

  task automatic test_done_held();
    for (int i = 0; i < 6; i++) begin
      idle(1);
      n_total++; if (loading !== 1'b1 || uart_ready !== 1'b1)
        $display("FAIL held_stay_load: got loading=%0b ready=%0b exp 1/1", loading, uart_ready); else n_pass++;
      advance();
    end
    idle(0);
    advance();
    idle(1);
    n_total++; if (uart_ready !== 1'b1) $display("FAIL held_rise_ready: got %0b exp 1", uart_ready); else n_pass++;
    advance();
    idle(1);
    n_total++; if (uart_ready !== 1'b0) $display("FAIL held_settle_ready: got %0b exp 0", uart_ready); else n_pass++;
    advance();
    // reload together with held done returns to LOAD and stays there
    drive(0, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      n_total++; if (uart_ready !== 1'b1) $display("FAIL held2_ready: got %0b exp 1", uart_ready); else n_pass++;
      advance();
    end
    idle(0);
    advance();
  endtask

  task automatic test_unaligned();
    drive(1, 32'h10, 32'h5555, 0, 0, 32'h0, 32'h0, 0);
    advance();
    drive(1, 32'h6, 32'h6666, 0, 0, 32'h0, 32'h0, 0);
    n_total++; if (mem_we !== 1'b1 || mem_addr !== 32'h10)
      $display("FAIL unal_prior_write: got we=%0b addr=%h exp 1/10", mem_we, mem_addr); else n_pass++;
    advance();
    idle(0);
    n_total++; if (mem_we !== 1'b0) $display("FAIL unal_no_write: got %0b exp 0", mem_we); else n_pass++;
    n_total++; if (load_err !== 1'b1) $display("FAIL unal_load_err: got %0b exp 1", load_err); else n_pass++;
    n_total++; if (word_cnt !== 16'd1) $display("FAIL unal_word_cnt: got %0d exp 1", word_cnt); else n_pass++;
    advance();
    drive(0, 32'h0, 32'h0, 0, 1, 32'h0, 32'h0, 0);
    advance();
    idle(0);
    n_total++; if (load_err !== 1'b0) $display("FAIL unal_reload_err: got %0b exp 0", load_err); else n_pass++;
    n_total++; if (word_cnt !== 16'd0) $display("FAIL unal_reload_cnt: got %0d exp 0", word_cnt); else n_pass++;
    advance();
  endtask

  task automatic test_saturation_and_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'(32'h100 + 4 * i), $urandom, 0, 0, 32'h0, 32'h0, 0);
      advance();
    end
    drive(1, 32'h203, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    n_total++; if (word_cnt2 !== 2'd3) $display("FAIL sat_word_cnt2: got %0d exp 3", word_cnt2); else n_pass++;
    n_total++; if (word_cnt !== 16'd5) $display("FAIL sat_word_cnt16: got %0d exp 5", word_cnt); else n_pass++;
    advance();
    drive(1, 32'h300, 32'hDEAD, 0, 0, 32'h0, 32'h0, 0);
    advance();
    // asynchronous reset between edges with a write pending and the error flag set
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
      $display("FAIL midrst_mem: got we=%0b addr=%h data=%h exp 0/0/0", mem_we, mem_addr, mem_wdata); else n_pass++;
    n_total++; if (uart_ready !== 1'b0 || cpu_rst_n !== 1'b0 || loading !== 1'b1)
      $display("FAIL midrst_ctrl: got ready=%0b cpu_rst_n=%0b loading=%0b exp 0/0/1", uart_ready, cpu_rst_n, loading); else n_pass++;
    n_total++; if (word_cnt !== 16'h0 || word_cnt2 !== 2'h0 || load_err !== 1'b0)
      $display("FAIL midrst_stats: got cnt=%0d cnt2=%0d err=%0b exp 0/0/0", word_cnt, word_cnt2, load_err); else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0);
    advance();
  endtask

  task automatic test_random();
    bit          v, dn, rl, cw;
    logic [31:0] a, d, ca, cd;
    dn = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      v  = ($urandom_range(3) != 0);
      a  = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(5) == 0) a[1:0] = 2'($urandom_range(3, 1));
      d  = $urandom;
      if ($urandom_range(19) == 0) dn = ~dn;
      rl = ($urandom_range(59) == 0);
      ca = $urandom; cd = $urandom; cw = $urandom_range(1) == 1;
      drive(v, a, d, dn, rl, ca, cd, cw);
      n_total++; if (uart_ready !== e_ready) $display("FAIL rnd_ready cyc %0d: got %0b exp %0b", cyc, uart_ready, e_ready); else n_pass++;
      n_total++; if (mem_we !== e_we) $display("FAIL rnd_we cyc %0d: got %0b exp %0b", cyc, mem_we, e_we); else n_pass++;
      n_total++; if (mem_addr !== e_addr) $display("FAIL rnd_addr cyc %0d: got %h exp %h", cyc, mem_addr, e_addr); else n_pass++;
      n_total++; if (mem_wdata !== e_wdata) $display("FAIL rnd_wdata cyc %0d: got %h exp %h", cyc, mem_wdata, e_wdata); else n_pass++;
      n_total++; if (cpu_rst_n !== e_crst) $display("FAIL rnd_cpu_rst_n cyc %0d: got %0b exp %0b", cyc, cpu_rst_n, e_crst); else n_pass++;
      n_total++; if (loading !== e_loading) $display("FAIL rnd_loading cyc %0d: got %0b exp %0b", cyc, loading, e_loading); else n_pass++;
      n_total++; if (load_err !== e_err) $display("FAIL rnd_load_err cyc %0d: got %0b exp %0b", cyc, load_err, e_err); else n_pass++;
      n_total++; if (word_cnt !== e_cnt16) $display("FAIL rnd_word_cnt cyc %0d: got %0d exp %0d", cyc, word_cnt, e_cnt16); else n_pass++;
      n_total++; if (word_cnt2 !== e_cnt2) $display("FAIL rnd_word_cnt2 cyc %0d: got %0d exp %0d", cyc, word_cnt2, e_cnt2); else n_pass++;
      advance();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    uart_valid = 1'b0; uart_addr = '0; uart_data = '0; uart_done = 1'b0; reload = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_back_to_back();
    test_done_settle();
    test_reload_run();
    test_done_held();
    test_unaligned();
    test_saturation_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
